// File: rtl/interrupt_controller.sv
// Timer interrupt arbiter and vector sequencer for the ATmega32A core.
// Define INTCTRL_EXT_INT0_EN to add the external INT0 source (vector 0x002).
module interrupt_controller #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          tifr,
    input  logic [7:0]          timsk,
    input  logic                sreg_i,
    input  logic                instr_boundary,
    input  logic                reti,
    input  logic [PC_WIDTH-1:0] program_counter,
`ifdef INTCTRL_EXT_INT0_EN
    input  logic                int0_req,
`endif
    output logic                hold,
    output logic                stack_we,
    output logic [7:0]          stack_data,
    output logic                PC_overwrite,
    output logic [PC_WIDTH-1:0] PC_new,
    output logic [7:0]          tifr_clear,
    output logic                clear_i,
    output logic                set_i,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        PUSH_L,
        PUSH_H,
        VECTOR
    } state_t;

    state_t      state;
    logic        block;
    logic [2:0]  win;
    logic [2:0]  win_next;
    logic [7:0]  pc_hi;
    logic [7:0]  pending;
    logic [15:0] pc16;
    logic [7:0]  vec;
    logic        req;
    logic        accept;
`ifdef INTCTRL_EXT_INT0_EN
    logic        int0_win;
`endif

    function automatic logic [7:0] timer_vector(input logic [2:0] idx);
        return 8'h16 - {4'd0, idx, 1'b0};
    endfunction

    assign pending = tifr & timsk;
    assign pc16    = 16'(program_counter);

`ifdef INTCTRL_EXT_INT0_EN
    assign req = (|pending) | int0_req;
    assign vec = int0_win ? 8'h02 : timer_vector(win);
`else
    assign req = |pending;
    assign vec = timer_vector(win);
`endif

    // RETI in the same cycle as a boundary also suppresses acceptance
    assign accept = (state == IDLE) && instr_boundary && sreg_i &&
                    req && !block && !reti;

    always_comb begin
        win_next = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) win_next = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            block        <= 1'b0;
            win          <= 3'd0;
            pc_hi        <= 8'd0;
`ifdef INTCTRL_EXT_INT0_EN
            int0_win     <= 1'b0;
`endif
            hold         <= 1'b0;
            stack_we     <= 1'b0;
            stack_data   <= 8'd0;
            PC_overwrite <= 1'b0;
            PC_new       <= '0;
            tifr_clear   <= 8'd0;
            clear_i      <= 1'b0;
            set_i        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            hold         <= 1'b0;
            stack_we     <= 1'b0;
            stack_data   <= 8'd0;
            PC_overwrite <= 1'b0;
            PC_new       <= '0;
            tifr_clear   <= 8'd0;
            clear_i      <= 1'b0;
            set_i        <= 1'b0;
            busy         <= 1'b0;
            unique case (state)
                IDLE: begin
                    set_i <= reti;
                    if (reti) begin
                        block <= 1'b1;
                    end else if (block && instr_boundary) begin
                        block <= 1'b0;
                    end
                    if (accept) begin
                        win        <= win_next;
`ifdef INTCTRL_EXT_INT0_EN
                        int0_win   <= int0_req;
`endif
                        pc_hi      <= pc16[15:8];
                        stack_data <= pc16[7:0];
                        hold       <= 1'b1;
                        busy       <= 1'b1;
                        stack_we   <= 1'b1;
                        state      <= PUSH_L;
                    end
                end
                PUSH_L: begin
                    stack_data <= pc_hi;
                    hold       <= 1'b1;
                    busy       <= 1'b1;
                    stack_we   <= 1'b1;
                    state      <= PUSH_H;
                end
                PUSH_H: begin
                    hold         <= 1'b1;
                    busy         <= 1'b1;
                    PC_overwrite <= 1'b1;
                    clear_i      <= 1'b1;
                    PC_new       <= PC_WIDTH'(vec);
`ifdef INTCTRL_EXT_INT0_EN
                    tifr_clear   <= int0_win ? 8'd0 : (8'd1 << win);
`else
                    tifr_clear   <= 8'd1 << win;
`endif
                    state        <= VECTOR;
                end
                VECTOR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a priority model predicts
// each service sequence and a negedge monitor checks what the DUT emits.
module tb_interrupt_controller;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    tifr = 8'd0;
    logic [7:0]    timsk = 8'd0;
    logic          sreg_i = 1'b0;
    logic          instr_boundary = 1'b0;
    logic          reti = 1'b0;
    logic [PW-1:0] program_counter = '0;
`ifdef INTCTRL_EXT_INT0_EN
    logic          int0_req = 1'b0;
`endif
    logic          hold;
    logic          stack_we;
    logic [7:0]    stack_data;
    logic          PC_overwrite;
    logic [PW-1:0] PC_new;
    logic [7:0]    tifr_clear;
    logic          clear_i;
    logic          set_i;
    logic          busy;

    interrupt_controller #(.PC_WIDTH(PW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tifr           (tifr),
        .timsk          (timsk),
        .sreg_i         (sreg_i),
        .instr_boundary (instr_boundary),
        .reti           (reti),
        .program_counter(program_counter),
`ifdef INTCTRL_EXT_INT0_EN
        .int0_req       (int0_req),
`endif
        .hold           (hold),
        .stack_we       (stack_we),
        .stack_data     (stack_data),
        .PC_overwrite   (PC_overwrite),
        .PC_new         (PC_new),
        .tifr_clear     (tifr_clear),
        .clear_i        (clear_i),
        .set_i          (set_i),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          start;
        logic [15:0] pc;
        logic [15:0] vec;
        logic [7:0]  clr;
    } txn_t;

    txn_t q[$];
    int   setq[$];
    int   last_start = -10;
    bit   block_m = 1'b0;
    int   asserts = 0;
    int   fails = 0;
    int   phase = 0;
    txn_t cur;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [36:0] outs;
        bit          es;
        outs = {hold, busy, stack_we, PC_overwrite, clear_i,
                stack_data, tifr_clear, PC_new};
        if (!reset_n) begin
            phase = 0;
            check("reset_outputs", {set_i, outs}, 64'd0);
        end else begin
            es = 1'b0;
            if (setq.size() > 0 && setq[0] == cyc) begin
                es = 1'b1;
                void'(setq.pop_front());
            end
            check("set_i", set_i, es);
            case (phase)
                0: begin
                    if (outs != 0) begin
                        if (q.size() == 0) begin
                            check("unexpected_seq", outs, 64'd0);
                        end else begin
                            cur = q.pop_front();
                            check("seq_start_cycle", cyc, cur.start);
                            check("push_l", outs,
                                  {5'b11100, cur.pc[7:0], 8'h00, 16'h0000});
                            phase = 1;
                        end
                    end else if (q.size() > 0 && q[0].start <= cyc) begin
                        check("seq_missing", hold, 1);
                        void'(q.pop_front());
                    end
                end
                1: begin
                    check("push_h", outs,
                          {5'b11100, cur.pc[15:8], 8'h00, 16'h0000});
                    phase = 2;
                end
                2: begin
                    check("vector", outs,
                          {5'b11011, 8'h00, cur.clr, cur.vec});
                    phase = 3;
                end
                default: begin
                    check("after_vector", outs, 64'd0);
                    phase = 0;
                end
            endcase
        end
    end

    task automatic drive(input bit b, input bit r, input bit s,
                         input logic [7:0] f, input logic [7:0] m,
                         input logic [15:0] pc, input bit i0);
        bit         idle;
        logic [7:0] p;
        txn_t       t;
`ifndef INTCTRL_EXT_INT0_EN
        i0 = 1'b0;
`else
        int0_req = i0;
`endif
        instr_boundary  = b;
        reti            = r;
        sreg_i          = s;
        tifr            = f;
        timsk           = m;
        program_counter = pc;
        idle = (cyc >= last_start + 3);
        p = f & m;
        if (idle) begin
            if (r) begin
                block_m = 1'b1;
                setq.push_back(cyc + 1);
            end else if (block_m) begin
                if (b) block_m = 1'b0;
            end else if (b && s && (p != 0 || i0)) begin
                t.start = cyc + 1;
                t.pc    = pc;
                t.vec   = 16'h0000;
                t.clr   = 8'h00;
                if (i0) begin
                    t.vec = 16'h0002;
                end else begin
                    for (int k = 7; k >= 0; k--) begin
                        if (p[k]) begin
                            t.vec = 16'h0016 - 16'(2 * k);
                            t.clr = 8'(1 << k);
                            break;
                        end
                    end
                end
                q.push_back(t);
                last_start = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int j = 0; j < n; j++) drive(0, 0, 0, 8'h00, 8'h00, 16'h0, 0);
    endtask

    initial begin
        bit          rb, rr, rs, ri;
        logic [7:0]  rf, rm;
        logic [15:0] rpc;

        #3;
        check("rst_hold", hold, 0);
        check("rst_stack_we", stack_we, 0);
        check("rst_stack_data", stack_data, 0);
        check("rst_pc_overwrite", PC_overwrite, 0);
        check("rst_pc_new", PC_new, 0);
        check("rst_tifr_clear", tifr_clear, 0);
        check("rst_clear_i", clear_i, 0);
        check("rst_set_i", set_i, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        nop(2);

        drive(1, 0, 1, 8'h01, 8'h01, 16'h0123, 0);
        nop(5);

        drive(1, 0, 1, 8'h81, 8'hFF, 16'h4567, 0);
        nop(4);
        repeat (5) drive(1, 0, 0, 8'h01, 8'hFF, 16'h1234, 0);
        drive(1, 0, 1, 8'h01, 8'hFF, 16'h89AB, 0);
        nop(4);

        repeat (5) drive(1, 0, 1, 8'hF0, 8'h0F, 16'h5555, 0);
        nop(2);

        drive(0, 1, 0, 8'h00, 8'h00, 16'h0000, 0);
        drive(1, 0, 1, 8'h02, 8'hFF, 16'h1111, 0);
        drive(0, 0, 1, 8'h02, 8'hFF, 16'h1111, 0);
        drive(1, 0, 1, 8'h02, 8'hFF, 16'h2222, 0);
        nop(4);

        drive(1, 1, 1, 8'h04, 8'hFF, 16'h3333, 0);
        drive(1, 0, 1, 8'h04, 8'hFF, 16'h3334, 0);
        drive(1, 0, 1, 8'h04, 8'hFF, 16'h3335, 0);
        nop(4);

        for (int j = 0; j < 5; j++)
            drive(1, 0, 1, 8'h10, 8'h10, 16'hAAA0 + 16'(j), 0);
        nop(4);

        drive(1, 0, 1, 8'h20, 8'h20, 16'hBEEF, 0);
        drive(0, 0, 0, 8'h20, 8'h20, 16'hBEEF, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_hold", hold, 0);
        check("midrst_stack_we", stack_we, 0);
        check("midrst_stack_data", stack_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pc_overwrite", PC_overwrite, 0);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        last_start = -10;
        block_m    = 1'b0;
        setq.delete();
        drive(1, 0, 1, 8'h20, 8'h20, 16'hCAFE, 0);
        nop(4);

`ifdef INTCTRL_EXT_INT0_EN
        drive(1, 0, 1, 8'h80, 8'hFF, 16'h0777, 1);
        nop(4);
`endif

        repeat (400) begin
            rb  = ($urandom_range(0, 1) == 1);
            rs  = ($urandom_range(0, 9) < 7);
            rr  = (cyc >= last_start + 3) && ($urandom_range(0, 9) == 0);
            rf  = 8'($urandom) & 8'($urandom);
            rm  = 8'($urandom);
            rpc = 16'($urandom);
            ri  = ($urandom_range(0, 7) == 0);
            drive(rb, rr, rs, rf, rm, rpc, ri);
        end
        nop(8);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Timer interrupt arbiter and vector sequencer for the ATmega32A core. Combines the joint TIFR flags with TIMSK and the SREG I bit, picks the highest-priority pending source at an instruction boundary, stalls fetch, pushes the return PC to the stack in two byte writes, and overwrites the PC with the source's vector. It also handles RETI re-enable of I. It sits between the timers, the control unit and prog_memory's PC_overwrite/PC_new/hold inputs.

## Interface
- PC_WIDTH, 16, width of program_counter and PC_new (word address)
- clk  in  1  system clock (sysClock)
- reset_n  in  1  asynchronous, active-low reset
- tifr  in  8  joint TIFR flags (timer0 | timer1)
- timsk  in  8  TIMSK mask register
- sreg_i  in  1  global interrupt enable (SREG I)
- instr_boundary  in  1  control unit: current instruction completes this cycle
- reti  in  1  control unit: RETI completes this cycle (one-cycle pulse)
- program_counter  in  PC_WIDTH  return address (PC of next instruction)
- hold  out  1  stall fetch/decode
- stack_we  out  1  stack byte write strobe
- stack_data  out  8  byte to push
- PC_overwrite  out  1  load PC_new into PC
- PC_new  out  PC_WIDTH  vector address
- tifr_clear  out  8  one-hot hardware clear of the serviced flag
- clear_i  out  1  clear SREG I
- set_i  out  1  set SREG I (RETI)
- busy  out  1  sequence in progress

## Operation
- pending = tifr & timsk. Priority: bit 7 highest, bit 0 lowest.
- Vectors (word address), bits 7..0: 0x008 (OCF2), 0x00A (TOV2), 0x00C (ICF1), 0x00E (OCF1A), 0x010 (OCF1B), 0x012 (TOV1), 0x014 (OCF0), 0x016 (TOV0). Zero-extend to PC_WIDTH.
- Accept when: state IDLE, instr_boundary=1, sreg_i=1, pending!=0, and block=0.
- On acceptance, latch the winner index and program_counter, then go to PUSH_L.
- FSM: IDLE -> PUSH_L -> PUSH_H -> VECTOR -> IDLE. All outputs are Moore, decoded from state and latched regs.
- PUSH_L: hold=1, busy=1, stack_we=1, stack_data=PC[7:0].
- PUSH_H: hold=1, busy=1, stack_we=1, stack_data=PC[15:8]. Upper bits above PC_WIDTH are zero.
- VECTOR: hold=1, busy=1, PC_overwrite=1, PC_new=vector, tifr_clear=1<<winner, clear_i=1.
- The winner is frozen once latched. Flags that rise during the sequence are not re-arbitrated. They stay pending in tifr.
- RETI:
  - reti=1 gives set_i=1 on the next cycle (registered).
  - It also sets block. block clears at the next instr_boundary after the reti cycle, so one instruction always executes after RETI.
- reti and instr_boundary in the same cycle: no acceptance that cycle. block still covers the following boundary.
- reti while not IDLE: ignored (it cannot occur, because the CPU is held).
- sreg_i, tifr and timsk changes while not IDLE: ignored.
- All outputs stay 0 in IDLE, except set_i as described.

## Timing
- Reset values: state IDLE, block=0, all outputs 0, PC_new=0, stack_data=0.
- Acceptance edge at cycle T gives:
  - PUSH_L during T+1
  - PUSH_H during T+2
  - VECTOR during T+3
  - IDLE at T+4
- hold is high for exactly 3 cycles. stack_we pulses for exactly 2 cycles. PC_overwrite pulses for 1 cycle.
- Earliest re-acceptance is T+4, and requires sreg_i to have been set again by software or RETI.
- reset_n low mid-sequence: immediate return to IDLE, all outputs 0, latched winner discarded, no partial vector.
- pending cleared in the same cycle as the acceptance edge: acceptance still proceeds on the sampled value.

## Configuration
- INTCTRL_EXT_INT0_EN
- Defined:
  - Adds input int0_req (1 bit, level, already synchronised by the GPIO block).
  - INT0 is highest priority, vector 0x002.
  - INT0 is included in acceptance.
  - tifr_clear stays 0 for INT0. The source owns its clear.
- Undefined: no int0_req port. Timer sources only.

## Test plan
- timsk=0x01, sreg_i=1, tifr=0x01, PC=0x0123, boundary pulse -> stack_data 0x23 then 0x01, PC_new=0x016, tifr_clear=0x01, clear_i=1 at T+3, hold 3 cycles.
- tifr=0x81, timsk=0xFF -> vector 0x008, tifr_clear=0x80. Bit 0 stays pending and is serviced only after sreg_i returns.
- sreg_i=0 or timsk&tifr=0 with boundary pulses -> hold, stack_we and PC_overwrite stay 0 indefinitely.
- reti pulse then pending 0x02 at the next boundary -> set_i next cycle, no acceptance at the first boundary, accept at the second, vector 0x014.
- reset_n low during PUSH_H -> all outputs 0 immediately. After release with pending still set, a fresh full 3-cycle sequence runs.
- INTCTRL_EXT_INT0_EN defined, int0_req=1 with tifr=0x80 -> PC_new=0x002, tifr_clear=0x00.
